// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: control decode, register file with write-back bypass,
// immediate generation, illegal detection and the ID/EX pipeline register.
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            valid_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  input  logic            hold_e,
  input  logic            flush_e,
  output logic [4:0]      rs1_d,
  output logic [4:0]      rs2_d,
  output logic            valid_e,
  output logic            illegal_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alu_src_e,
  output logic            alu_a_pc_e,
  output logic [1:0]      result_src_e,
  output logic [3:0]      alu_control_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic            alu_a_pc;
    logic [1:0]      result_src;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
  logic [XLEN-1:0] rd1, rd2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            alt;
  logic            illegal_op, use_rs1, use_rs2, use_rd, bad_idx, illegal;
  idex_t           dec, ex_q, ex_d;

  // funct3 -> ALU op; alt picks sub/sra on the two funct3 codes that have them
  function automatic logic [3:0] alu_fn(input logic [2:0] fn3, input logic sel_alt);
    case (fn3)
      3'b000:  return sel_alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return sel_alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];
  assign opcode = instr_d[6:0];
  assign f3     = instr_d[14:12];
  assign alt    = instr_d[30];

  assign imm_i = XLEN'($signed(instr_d[31:20]));
  assign imm_s = XLEN'($signed({instr_d[31:25], instr_d[11:7]}));
  assign imm_b = XLEN'($signed({instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr_d[31:12], 12'b0}));

  // Register file next state: x0 and out-of-range indices never get written
  always_comb begin
    rf_d = rf_q;
    for (int i = 1; i < NREGS; i++)
      if (reg_write_w && rd_w == 5'(i)) rf_d[i] = result_w;
    rf_d[0] = '0;
  end

  // Read ports; a same-cycle write-back to the source register wins
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1_d == 5'(i)) rd1 = rf_q[i];
      if (rs2_d == 5'(i)) rd2 = rf_q[i];
    end
    if (reg_write_w && rd_w == rs1_d && rs1_d != 5'd0) rd1 = result_w;
    if (reg_write_w && rd_w == rs2_d && rs2_d != 5'd0) rd2 = result_w;
  end

  // Opcode decode into the ID/EX payload; strobes are killed on illegal or bubble
  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    dec.rd1    = rd1;
    dec.rd2    = rd2;
    dec.pc     = pc_d;
    dec.pc4    = pc_plus4_d;
    dec.rs1    = rs1_d;
    dec.rs2    = rs2_d;
    dec.rd     = instr_d[11:7];
    illegal_op = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1; dec.alu_control = alu_fn(f3, alt);
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i;
        dec.alu_control = alu_fn(f3, alt && f3 == 3'b101);
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01;
        dec.alu_control = ALU_ADD; dec.imm = imm_i;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.alu_control = ALU_ADD; dec.imm = imm_s;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1; dec.imm = imm_b;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3[2:1])
          2'b00:   dec.alu_control = ALU_SUB;
          2'b10:   dec.alu_control = ALU_SLT;
          2'b11:   dec.alu_control = ALU_SLTU;
          default: illegal_op = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.imm = imm_j;
        use_rd = 1'b1;
      end
      OP_JALR: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b10;
        dec.alu_control = ALU_ADD; dec.imm = imm_i;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_control = ALU_PASSB; dec.imm = imm_u;
        use_rd = 1'b1;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_a_pc = 1'b1;
        dec.alu_control = ALU_ADD; dec.imm = imm_u;
        use_rd = 1'b1;
      end
      default: illegal_op = 1'b1;
    endcase
    bad_idx = (use_rs1 && int'(rs1_d) >= NREGS) ||
              (use_rs2 && int'(rs2_d) >= NREGS) ||
              (use_rd  && int'(instr_d[11:7]) >= NREGS);
    illegal     = illegal_op || bad_idx;
    dec.valid   = valid_d;
    dec.illegal = valid_d && illegal;
    if (illegal || !valid_d) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = 1'b0;
      dec.branch    = 1'b0;
    end
  end

  // ID/EX next state: flush beats hold; flush still loads the datapath fields
  always_comb begin
    ex_d = ex_q;
    if (flush_e) begin
      ex_d           = dec;
      ex_d.valid     = 1'b0;
      ex_d.illegal   = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.jump      = 1'b0;
      ex_d.branch    = 1'b0;
    end else if (!hold_e) begin
      ex_d = dec;
    end
  end

  // Register file state, cleared by reset; writes continue during hold
  always_ff @(posedge clk) begin
    if (!srst) rf_q <= '0;
    else       rf_q <= rf_d;
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (!srst) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign valid_e       = ex_q.valid;
  assign illegal_e     = ex_q.illegal;
  assign reg_write_e   = ex_q.reg_write;
  assign mem_write_e   = ex_q.mem_write;
  assign jump_e        = ex_q.jump;
  assign branch_e      = ex_q.branch;
  assign alu_src_e     = ex_q.alu_src;
  assign alu_a_pc_e    = ex_q.alu_a_pc;
  assign result_src_e  = ex_q.result_src;
  assign alu_control_e = ex_q.alu_control;
  assign funct3_e      = ex_q.funct3;
  assign rd1_e         = ex_q.rd1;
  assign rd2_e         = ex_q.rd2;
  assign imm_ext_e     = ex_q.imm;
  assign pc_e          = ex_q.pc;
  assign pc_plus4_e    = ex_q.pc4;
  assign rs1_e         = ex_q.rs1;
  assign rs2_e         = ex_q.rs2;
  assign rd_e          = ex_q.rd;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus randomized traffic
// scored against an instruction-level reference model.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, valid_d, reg_write_w, hold_e, flush_e;
  logic [31:0] instr_d, pc_d, pc_plus4_d, result_w;
  logic [4:0]  rd_w;

  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
  logic        valid_e, illegal_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_a_pc_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_control_e;
  logic [2:0]  funct3_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;

  logic [4:0]  h_rs1_d, h_rs2_d, h_rs1_e, h_rs2_e, h_rd_e;
  logic        h_valid_e, h_illegal_e, h_reg_write_e, h_mem_write_e, h_jump_e, h_branch_e, h_alu_src_e, h_alu_a_pc_e;
  logic [1:0]  h_result_src_e;
  logic [3:0]  h_alu_control_e;
  logic [2:0]  h_funct3_e;
  logic [31:0] h_rd1_e, h_rd2_e, h_imm_ext_e, h_pc_e, h_pc_plus4_e;

  decode_stage_pipe #(.XLEN(32), .NREGS(32)) u_dut (
    .clk(clk), .srst(srst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .hold_e(hold_e), .flush_e(flush_e),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .valid_e(valid_e), .illegal_e(illegal_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .alu_a_pc_e(alu_a_pc_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
    .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e));

  decode_stage_pipe #(.XLEN(32), .NREGS(16)) u_dut16 (
    .clk(clk), .srst(srst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .hold_e(hold_e), .flush_e(flush_e),
    .rs1_d(h_rs1_d), .rs2_d(h_rs2_d), .valid_e(h_valid_e), .illegal_e(h_illegal_e), .reg_write_e(h_reg_write_e),
    .mem_write_e(h_mem_write_e), .jump_e(h_jump_e), .branch_e(h_branch_e), .alu_src_e(h_alu_src_e),
    .alu_a_pc_e(h_alu_a_pc_e), .result_src_e(h_result_src_e), .alu_control_e(h_alu_control_e),
    .funct3_e(h_funct3_e), .rd1_e(h_rd1_e), .rd2_e(h_rd2_e), .imm_ext_e(h_imm_ext_e), .pc_e(h_pc_e),
    .pc_plus4_e(h_pc_plus4_e), .rs1_e(h_rs1_e), .rs2_e(h_rs2_e), .rd_e(h_rd_e));

  logic [191:0] obs, h_obs;
  assign obs = {valid_e, illegal_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_a_pc_e,
                result_src_e, alu_control_e, funct3_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
                rs1_e, rs2_e, rd_e};
  assign h_obs = {h_valid_e, h_illegal_e, h_reg_write_e, h_mem_write_e, h_jump_e, h_branch_e, h_alu_src_e,
                  h_alu_a_pc_e, h_result_src_e, h_alu_control_e, h_funct3_e, h_rd1_e, h_rd2_e, h_imm_ext_e,
                  h_pc_e, h_pc_plus4_e, h_rs1_e, h_rs2_e, h_rd_e};

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (NREGS = 32) ----------------
  // funct3 -> ALU code for the arithmetic ops; branch funct3 -> compare op
  localparam int R_MAP [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  localparam int B_MAP [8] = '{1, 1, 0, 0, 5, 5, 6, 6};

  logic [31:0]  m_rf [32];
  logic [191:0] m_exp, m_msk, m_e, m_m;
  logic [31:0]  m_a, m_b;

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (reg_write_w && rd_w == r) return result_w;
    return m_rf[r];
  endfunction

  task automatic model_decode(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] a, input logic [31:0] b,
                              output logic [191:0] e, output logic [191:0] m);
    logic signed [31:0] s;
    logic [31:0] imm, imm_i, imm_s, imm_b, imm_j, imm_u;
    logic rw, mw, jp, br, as, apc, legal, ctl_ok, alu_ok;
    logic [1:0] rsrc;
    logic [3:0] alu;
    logic [2:0] f3;
    s     = ins;
    f3    = ins[14:12];
    imm_i = 32'(s >>> 20);
    imm_s = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    imm_b = 32'(int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - int'(ins[31]) * 4096);
    imm_j = 32'(int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - int'(ins[31]) * 1048576);
    imm_u = ins & 32'hFFFF_F000;
    {rw, mw, jp, br, as, apc} = 6'b0;
    rsrc = 2'd0; alu = 4'd0; imm = 32'd0;
    legal = 1'b1; ctl_ok = 1'b1; alu_ok = 1'b1;
    case (ins[6:0])
      7'h33: begin rw = 1; alu = 4'(R_MAP[f3]);
                   if (ins[30] && f3 == 3'd0) alu = 4'd1;
                   if (ins[30] && f3 == 3'd5) alu = 4'd9; end
      7'h13: begin rw = 1; as = 1; imm = imm_i; alu = 4'(R_MAP[f3]);
                   if (ins[30] && f3 == 3'd5) alu = 4'd9; end
      7'h03: begin rw = 1; as = 1; rsrc = 2'd1; imm = imm_i; end
      7'h23: begin mw = 1; as = 1; imm = imm_s; end
      7'h63: begin br = 1; imm = imm_b; alu = 4'(B_MAP[f3]);
                   if (f3 == 3'd2 || f3 == 3'd3) begin legal = 0; ctl_ok = 0; alu_ok = 0; end end
      7'h6F: begin jp = 1; rw = 1; rsrc = 2'd2; imm = imm_j; alu_ok = 0; end
      7'h67: begin jp = 1; rw = 1; as = 1; rsrc = 2'd2; imm = imm_i; end
      7'h37: begin rw = 1; as = 1; alu = 4'd10; imm = imm_u; end
      7'h17: begin rw = 1; as = 1; apc = 1; imm = imm_u; end
      default: begin legal = 0; ctl_ok = 0; alu_ok = 0; end
    endcase
    if (!legal || !v) {rw, mw, jp, br} = 4'b0;
    e = {v, v && !legal, rw, mw, jp, br, as, apc, rsrc, alu, f3, a, b, imm, pc, pc4,
         ins[19:15], ins[24:20], ins[11:7]};
    m = {6'h3F, ctl_ok, ctl_ok, {2{ctl_ok}}, {4{alu_ok}}, 3'h7, {64{1'b1}}, {32{ctl_ok}},
         {64{1'b1}}, 15'h7FFF};
  endtask

  // Model advances on the same edge as the DUT, from the same inputs
  always @(posedge clk) begin
    if (!srst) begin
      m_exp = '0;
      m_msk = '1;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      m_a = m_read(instr_d[19:15]);
      m_b = m_read(instr_d[24:20]);
      model_decode(valid_d, instr_d, pc_d, pc_plus4_d, m_a, m_b, m_e, m_m);
      if (flush_e) begin
        m_exp = {6'b0, m_e[185:0]};
        m_msk = {6'h3F, 186'b0};
      end else if (!hold_e) begin
        m_exp = m_e;
        m_msk = m_m;
      end
      if (reg_write_w && rd_w != 5'd0) m_rf[rd_w] = result_w;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_d = 1'b1; instr_d = 32'h0000_0013; pc_d = 32'h100; pc_plus4_d = 32'h104;
    reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'd0; hold_e = 1'b0; flush_e = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    srst = 1'b0;
    instr_d = 32'h0050_0093; // addi x1, x0, 5
    step(); step();
    checks++;
    if (obs !== 192'd0) begin errors++; $display("FAIL reset_e_outputs: got %h want 0", obs); end
    srst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      instr_d = {7'd0, r, r, 3'd0, 5'd0, 7'h33};
      step();
      checks++;
      if (rd1_e !== 32'd0 || rd2_e !== 32'd0) begin
        errors++; $display("FAIL reset_reg_x%0d: got %h/%h want 0", i, rd1_e, rd2_e);
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'h1234;
    instr_d = 32'h0052_8333; // add x6, x5, x5
    #1;
    checks++;
    if (rs1_d !== 5'd5 || rs2_d !== 5'd5) begin
      errors++; $display("FAIL rs_d_fields: got %0d/%0d want 5/5", rs1_d, rs2_d);
    end
    step();
    reg_write_w = 1'b0;
    checks++;
    if (rd1_e !== 32'h1234 || rd2_e !== 32'h1234 || alu_control_e !== 4'd0 || reg_write_e !== 1'b1 || rd_e !== 5'd6) begin
      errors++; $display("FAIL bypass: got rd1=%h rd2=%h alu=%0d rw=%b rd=%0d want 1234 1234 0 1 6",
                         rd1_e, rd2_e, alu_control_e, reg_write_e, rd_e);
    end
    step();
    checks++;
    if (rd1_e !== 32'h1234) begin errors++; $display("FAIL regfile_after_write: got %h want 1234", rd1_e); end
  endtask

  task automatic test_immediates();
    idle_inputs();
    instr_d = 32'hFE00_0EE3; // beq x0, x0, -4
    step();
    checks++;
    if (imm_ext_e !== 32'hFFFF_FFFC || branch_e !== 1'b1 || alu_control_e !== 4'd1 || reg_write_e !== 1'b0) begin
      errors++; $display("FAIL imm_beq: got imm=%h br=%b alu=%0d rw=%b want fffffffc 1 1 0",
                         imm_ext_e, branch_e, alu_control_e, reg_write_e);
    end
    instr_d = 32'hABCD_E0B7; // lui x1, 0xABCDE
    step();
    checks++;
    if (imm_ext_e !== 32'hABCD_E000 || alu_control_e !== 4'd10 || rd_e !== 5'd1 || alu_src_e !== 1'b1) begin
      errors++; $display("FAIL imm_lui: got imm=%h alu=%0d rd=%0d src=%b want abcde000 10 1 1",
                         imm_ext_e, alu_control_e, rd_e, alu_src_e);
    end
  endtask

  task automatic test_hold_flush();
    idle_inputs();
    instr_d = 32'h0040_A183; // lw x3, 4(x1)
    step();
    checks++;
    if (result_src_e !== 2'b01 || reg_write_e !== 1'b1 || imm_ext_e !== 32'd4) begin
      errors++; $display("FAIL load_decode: got rs=%0d rw=%b imm=%h want 1 1 4", result_src_e, reg_write_e, imm_ext_e);
    end
    instr_d = 32'h0020_A423; // sw x2, 8(x1)
    hold_e = 1'b1;
    step();
    checks++;
    if (mem_write_e !== 1'b0 || reg_write_e !== 1'b1 || rd_e !== 5'd3 || imm_ext_e !== 32'd4 || result_src_e !== 2'b01) begin
      errors++; $display("FAIL hold: got mw=%b rw=%b rd=%0d imm=%h want 0 1 3 4", mem_write_e, reg_write_e, rd_e, imm_ext_e);
    end
    flush_e = 1'b1;
    step();
    checks++;
    if (valid_e !== 1'b0 || mem_write_e !== 1'b0 || reg_write_e !== 1'b0) begin
      errors++; $display("FAIL flush_over_hold: got v=%b mw=%b rw=%b want 0 0 0", valid_e, mem_write_e, reg_write_e);
    end
    hold_e = 1'b0; flush_e = 1'b0;
    step();
    checks++;
    if (mem_write_e !== 1'b1 || imm_ext_e !== 32'd8 || valid_e !== 1'b1) begin
      errors++; $display("FAIL store_after_flush: got mw=%b imm=%h v=%b want 1 8 1", mem_write_e, imm_ext_e, valid_e);
    end
  endtask

  task automatic test_illegal();
    idle_inputs();
    instr_d = 32'h0000_007F;
    step();
    checks++;
    if (illegal_e !== 1'b1 || {reg_write_e, mem_write_e, jump_e, branch_e} !== 4'b0) begin
      errors++; $display("FAIL illegal_opcode: got ill=%b strobes=%b want 1 0000",
                         illegal_e, {reg_write_e, mem_write_e, jump_e, branch_e});
    end
    valid_d = 1'b0;
    step();
    checks++;
    if (illegal_e !== 1'b0 || valid_e !== 1'b0) begin
      errors++; $display("FAIL bubble_illegal: got ill=%b v=%b want 0 0", illegal_e, valid_e);
    end
    valid_d = 1'b1;
    instr_d = 32'h0000_2063; // branch with funct3 010
    step();
    checks++;
    if (illegal_e !== 1'b1 || branch_e !== 1'b0) begin
      errors++; $display("FAIL illegal_branch_f3: got ill=%b br=%b want 1 0", illegal_e, branch_e);
    end
    instr_d = 32'h0020_88B3; // add x17, x1, x2
    #1;
    checks++;
    if (h_rs1_d !== 5'd1 || h_rs2_d !== 5'd2) begin
      errors++; $display("FAIL rs_d_rv32e: got %0d/%0d want 1/2", h_rs1_d, h_rs2_d);
    end
    step();
    checks++;
    if (h_illegal_e !== 1'b1 || h_reg_write_e !== 1'b0 || illegal_e !== 1'b0 || reg_write_e !== 1'b1) begin
      errors++; $display("FAIL reg_index_range: got ill16=%b rw16=%b ill32=%b rw32=%b want 1 0 0 1",
                         h_illegal_e, h_reg_write_e, illegal_e, reg_write_e);
    end
    instr_d = 32'h0031_0093; // addi x1, x2, 3
    step();
    checks++;
    if ((h_obs & m_msk) !== (m_exp & m_msk)) begin
      errors++; $display("FAIL rv32e_legal: got %h want %h", h_obs & m_msk, m_exp & m_msk);
    end
  endtask

  task automatic test_x0();
    idle_inputs();
    reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'hFFFF_FFFF;
    instr_d = 32'h0000_03B3; // add x7, x0, x0
    step();
    reg_write_w = 1'b0;
    checks++;
    if (rd1_e !== 32'd0 || rd2_e !== 32'd0) begin
      errors++; $display("FAIL x0_bypass: got %h/%h want 0", rd1_e, rd2_e);
    end
    step();
    checks++;
    if (rd1_e !== 32'd0) begin errors++; $display("FAIL x0_stored: got %h want 0", rd1_e); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      r           = $urandom;
      instr_d     = {r[31:7], ops[$urandom_range(0, 9)]};
      valid_d     = ($urandom_range(0, 7) != 0);
      pc_d        = $urandom & 32'hFFFF_FFFC;
      pc_plus4_d  = pc_d + 32'd4;
      reg_write_w = $urandom_range(0, 1) == 1;
      rd_w        = 5'($urandom_range(0, 31));
      result_w    = $urandom;
      hold_e      = ($urandom_range(0, 5) == 0);
      flush_e     = ($urandom_range(0, 7) == 0);
      srst        = ($urandom_range(0, 39) != 0);
      step();
      checks++;
      if ((obs & m_msk) !== (m_exp & m_msk)) begin
        errors++; $display("FAIL random_%0d: got %h want %h", n, obs & m_msk, m_exp & m_msk);
      end
    end
    srst = 1'b1;
  endtask

  initial begin
    srst = 1'b0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_immediates();
    test_hold_flush();
    test_illegal();
    test_x0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
